// File: rtl/sram_pkg.sv
// Shared helpers for the SRAM array: read-latency derivation, word-lane count
// and the row/word geometry check used at elaboration.
package sram_pkg;

    // Extra read pipeline stages beyond the registered array read.
    // Deeper arrays and more ports need more time through the macro.
    function automatic int sram_delay(input int logdepth, input int ports);
        int rows_f;
        int port_f;
        rows_f = (logdepth - 8 > 0) ? (logdepth - 8) : 1;
        port_f = (ports > 1) ? ((ports > 2) ? ((ports > 3) ? 100 : 20) : 14) : 10;
        return (rows_f * port_f) / 10 - 1;
    endfunction

    // Number of independently writable word lanes in a row.
    function automatic int sram_nwords(input int width, input int wordsize);
        return width / wordsize;
    endfunction

    // A row must split evenly into word lanes.
    function automatic bit sram_width_ok(input int width, input int wordsize);
        return (wordsize > 0) && (width % wordsize == 0);
    endfunction

endpackage

// File: rtl/sram_delay_pipe.sv
// Resettable register chain that delays array read data by STAGES cycles.
// With STAGES = 0 it degenerates to a wire.
module sram_delay_pipe #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (STAGES == 0) begin : g_pass
        logic unused_pipe;
        assign unused_pipe = &{1'b0, clk, rst_n};
        assign q_o = d_i;
    end else begin : g_chain
        logic [WIDTH-1:0] stage_q [STAGES];

        // Shift read data one stage per clock; all stages clear on reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < STAGES; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q[0] <= d_i;
                for (int i = 1; i < STAGES; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q_o = stage_q[STAGES-1];
    end

endmodule

// File: rtl/sram_array.sv
// Single-read, single-write synchronous memory with per-word write enables.
// Reads are read-first against a same-row write; the registered array read is
// followed by DELAY extra pipeline stages, giving DELAY+1 cycles of latency.
module sram_array
    import sram_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int LOGDEPTH = 9,
    parameter int WORDSIZE = 64,
    parameter int PORTS    = 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [LOGDEPTH-1:0]                   readAddr,
    output logic [WIDTH-1:0]                      readData,
    input  logic [LOGDEPTH-1:0]                   writeAddr,
    input  logic [WIDTH-1:0]                      writeData,
    input  logic [sram_nwords(WIDTH,WORDSIZE)-1:0] writeEnable
);

    localparam int NWORDS = sram_nwords(WIDTH, WORDSIZE);
    localparam int DEPTH  = 1 << LOGDEPTH;
    localparam int DELAY  = sram_delay(LOGDEPTH, PORTS);

    if (!sram_width_ok(WIDTH, WORDSIZE)) begin : g_width_chk
        $error("sram_array: WIDTH must be a multiple of WORDSIZE");
    end

    wire [WIDTH-1:0] rd_row;

    // Each word lane owns its own storage column, so lane writes never
    // contend and the row read is simply the concatenation of the lanes.
    for (genvar j = 0; j < NWORDS; j++) begin : g_lane
        logic [WORDSIZE-1:0] mem_q [DEPTH];
        logic [WORDSIZE-1:0] rd_d;
        logic [WORDSIZE-1:0] rd_q;

        assign rd_d = mem_q[readAddr];

        // Lane write; storage is never cleared, writes are blocked while in reset.
        always_ff @(posedge clk or negedge reset) begin
            if (reset) begin
                if (writeEnable[j]) begin
                    mem_q[writeAddr] <= writeData[j*WORDSIZE +: WORDSIZE];
                end
            end
        end

        // Registered lane read; samples the pre-write contents (read-first).
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rd_q <= '0;
            end else begin
                rd_q <= rd_d;
            end
        end

        assign rd_row[j*WORDSIZE +: WORDSIZE] = rd_q;
    end

    sram_delay_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (DELAY)
    ) u_delay_pipe (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (rd_row),
        .q_o   (readData)
    );

endmodule

// File: tb/tb_sram_array.sv
// Bench for sram_array: three instances (512-bit line data, 50-bit tag,
// 4096-deep array) checked every cycle against a row-level reference model.
module tb_sram_array;

    // Latencies worked out by hand from the delay formula.
    localparam int DLY_A = 0;   // LOGDEPTH 9, 1 port
    localparam int DLY_B = 0;   // LOGDEPTH 9, 1 port
    localparam int DLY_C = 3;   // LOGDEPTH 12: 4*10/10-1

    logic clk;
    logic rst_n;

    logic [8:0]   ra_a, wa_a;
    logic [511:0] wd_a, rd_a;
    logic [7:0]   we_a;

    logic [8:0]   ra_b, wa_b;
    logic [49:0]  wd_b, rd_b;
    logic [0:0]   we_b;

    logic [11:0]  ra_c, wa_c;
    logic [63:0]  wd_c, rd_c;
    logic [0:0]   we_c;

    sram_array #(.WIDTH(512), .LOGDEPTH(9), .WORDSIZE(64)) u_dut_a (
        .clk(clk), .reset(rst_n), .readAddr(ra_a), .readData(rd_a),
        .writeAddr(wa_a), .writeData(wd_a), .writeEnable(we_a));

    sram_array #(.WIDTH(50), .LOGDEPTH(9), .WORDSIZE(50)) u_dut_b (
        .clk(clk), .reset(rst_n), .readAddr(ra_b), .readData(rd_b),
        .writeAddr(wa_b), .writeData(wd_b), .writeEnable(we_b));

    sram_array #(.WIDTH(64), .LOGDEPTH(12), .WORDSIZE(64)) u_dut_c (
        .clk(clk), .reset(rst_n), .readAddr(ra_c), .readData(rd_c),
        .writeAddr(wa_c), .writeData(wd_c), .writeEnable(we_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: row contents, which rows hold known data, and the
    // queue of reads still travelling toward readData.
    typedef struct {
        logic [511:0] v;
        bit           k;
    } exp_t;

    logic [511:0] mem_a [512];
    bit           val_a [512];
    logic [49:0]  mem_b [512];
    bit           val_b [512];
    logic [63:0]  mem_c [4096];
    bit           val_c [4096];

    exp_t qa[$], qb[$], qc[$];
    exp_t cur_a, cur_b, cur_c;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [49:0] rand50();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[49:0];
    endfunction

    task automatic model_clear();
        qa.delete(); qb.delete(); qc.delete();
        cur_a = '{v: '0, k: 1'b1};
        cur_b = '{v: '0, k: 1'b1};
        cur_c = '{v: '0, k: 1'b1};
    endtask

    // Apply one rising edge to the model: reads see the old row, then writes land.
    task automatic model_edge();
        exp_t e;
        if (!rst_n) begin
            model_clear();
            return;
        end
        e.k = val_a[ra_a]; e.v = mem_a[ra_a];
        qa.push_back(e);
        if (qa.size() > DLY_A) cur_a = qa.pop_front();
        e.k = val_b[ra_b]; e.v = 512'(mem_b[ra_b]);
        qb.push_back(e);
        if (qb.size() > DLY_B) cur_b = qb.pop_front();
        e.k = val_c[ra_c]; e.v = 512'(mem_c[ra_c]);
        qc.push_back(e);
        if (qc.size() > DLY_C) cur_c = qc.pop_front();

        for (int j = 0; j < 8; j++)
            if (we_a[j]) mem_a[wa_a][j*64 +: 64] = wd_a[j*64 +: 64];
        if (we_a == 8'hFF) val_a[wa_a] = 1'b1;
        if (we_b[0]) begin mem_b[wa_b] = wd_b; val_b[wa_b] = 1'b1; end
        if (we_c[0]) begin mem_c[wa_c] = wd_c; val_c[wa_c] = 1'b1; end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (cur_a.k) chk("model_a", rd_a, cur_a.v);
        if (cur_b.k) chk("model_b", 512'(rd_b), cur_b.v);
        if (cur_c.k) chk("model_c", 512'(rd_c), cur_c.v);
    endtask

    task automatic no_writes();
        we_a = '0; we_b = '0; we_c = '0;
    endtask

    // Assert reset between edges; outputs must clear without waiting for a clock.
    task automatic reset_now();
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        chk("rst_a", rd_a, '0);
        chk("rst_b", 512'(rd_b), '0);
        chk("rst_c", 512'(rd_c), '0);
    endtask

    task automatic release_now();
        #2 rst_n = 1'b1;
    endtask

    logic [511:0] t1_data, t3_a, t3_b, exp512;
    logic [63:0]  t5_data, old10;
    int           r;

    initial begin
        rst_n = 1'b0;
        ra_a = '0; wa_a = '0; wd_a = '0; we_a = '0;
        ra_b = '0; wa_b = '0; wd_b = '0; we_b = '0;
        ra_c = '0; wa_c = '0; wd_c = '0; we_c = '0;
        model_clear();
        #1;
        chk("reset_a", rd_a, '0);
        chk("reset_c", 512'(rd_c), '0);
        repeat (2) tick();
        release_now();

        // Give rows 0..16 of every instance and row 4095 of the deep one known data.
        for (int i = 0; i < 17; i++) begin
            wa_a = 9'(i); wd_a = rand512(); we_a = 8'hFF;
            wa_b = 9'(i); wd_b = rand50();  we_b = 1'b1;
            wa_c = (i == 16) ? 12'd4095 : 12'(i);
            wd_c = {$urandom(), $urandom()}; we_c = 1'b1;
            tick();
        end
        no_writes();

        // Basic write then read one cycle later.
        t1_data = {16{32'hDEADBEEF}};
        wa_a = 9'd5; wd_a = t1_data; we_a = 8'hFF; ra_a = 9'd0;
        tick();
        no_writes(); ra_a = 9'd5;
        tick();
        chk("t1_read", rd_a, t1_data);

        // Partial write clears only word 2.
        wa_a = 9'd3; wd_a = '1; we_a = 8'hFF;
        tick();
        wd_a = '0; we_a = 8'b0000_0100;
        tick();
        no_writes(); ra_a = 9'd3;
        tick();
        exp512 = '1;
        exp512[128 +: 64] = 64'h0;
        chk("t2_partial", rd_a, exp512);

        // Same-row read and write: old data now, new data next read.
        t3_a = rand512(); t3_b = ~t3_a;
        wa_a = 9'd7; wd_a = t3_a; we_a = 8'hFF;
        tick();
        wd_a = t3_b; ra_a = 9'd7;
        tick();
        chk("t3_read_first", rd_a, t3_a);
        no_writes();
        tick();
        chk("t3_next_read", rd_a, t3_b);

        // Tag instance: back-to-back reads return on consecutive cycles.
        for (int i = 0; i < 3; i++) begin
            wa_b = 9'(i); wd_b = 50'(i + 1); we_b = 1'b1;
            tick();
        end
        no_writes();
        for (int i = 0; i < 3; i++) begin
            ra_b = 9'(i);
            tick();
            chk("t4_tag", 512'(rd_b), 512'(i + 1));
        end

        // Deep array: four-cycle latency.
        old10 = mem_c[10];
        t5_data = ~old10;
        wa_c = 12'd4095; wd_c = t5_data; we_c = 1'b1; ra_c = 12'd10;
        tick();
        no_writes(); ra_c = 12'd4095;
        tick();
        ra_c = 12'd0;
        tick();
        tick();
        chk("t5_early", 512'(rd_c), 512'(old10));
        tick();
        chk("t5_lat4", 512'(rd_c), 512'(t5_data));

        for (int i = 1; i <= 4; i++) begin
            wa_c = 12'(i); wd_c = 64'h100 + 64'(i); we_c = 1'b1;
            tick();
        end
        no_writes();
        for (int i = 1; i <= 4; i++) begin
            ra_c = 12'(i);
            tick();
        end
        chk("t5_order", 512'(rd_c), 512'h101);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk("t5_order", 512'(rd_c), 512'(64'h100 + 64'(i)));
        end

        // Reset mid-read: immediate clear, write blocked, contents kept.
        ra_a = 9'd5; ra_c = 12'd4095;
        tick();
        reset_now();
        wa_a = 9'd5; wd_a = '0; we_a = 8'hFF;
        wa_c = 12'd4095; wd_c = '0; we_c = 1'b1;
        tick();
        no_writes();
        tick();
        release_now();
        tick();
        chk("t6_keep_a", rd_a, t1_data);
        chk("t6_hold_c", 512'(rd_c), '0);
        repeat (3) tick();
        chk("t6_keep_c", 512'(rd_c), 512'(t5_data));

        // Randomized traffic over the initialized rows, with occasional resets.
        for (int n = 0; n < 400; n++) begin
            ra_a = 9'($urandom_range(0, 16));
            wa_a = 9'($urandom_range(0, 16));
            wd_a = rand512();
            we_a = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom());
            ra_b = 9'($urandom_range(0, 16));
            wa_b = 9'($urandom_range(0, 16));
            wd_b = rand50();
            we_b = 1'($urandom());
            r = $urandom_range(0, 16);
            ra_c = (r == 16) ? 12'd4095 : 12'(r);
            r = $urandom_range(0, 16);
            wa_c = (r == 16) ? 12'd4095 : 12'(r);
            wd_c = {$urandom(), $urandom()};
            we_c = 1'($urandom());
            tick();
            if ($urandom_range(0, 63) == 0) begin
                reset_now();
                tick();
                release_now();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
